// File: rtl/mult_control.sv
// rtl/mult_control.sv - shift-add multiplier sequencer: one CHECK and one SHIFT cycle per multiplier bit
module mult_control #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       LSB,
   output logic       ADDU_ctrl,
   output logic       W_ctrl,
   output logic       SRL_ctrl,
   output logic       Ready,
   output logic       Done,
   output logic [5:0] Count
);

   typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

   localparam logic [5:0] LAST_COUNT = 6'(WIDTH);

   state_t     state_q, state_d;
   logic [5:0] count_q, count_d;
   logic       done_q, done_d;

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= IDLE;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   // LSB is only consulted in CHECK, so an unknown LSB elsewhere cannot reach the strobes.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      ADDU_ctrl = 1'b0;
      W_ctrl    = 1'b0;
      SRL_ctrl  = 1'b0;
      Ready     = 1'b0;
      case (state_q)
         IDLE: begin
            Ready   = 1'b1;
            count_d = '0;
            if (Run) state_d = CHECK;
         end
         CHECK: begin
            ADDU_ctrl = LSB;
            W_ctrl    = LSB;
            state_d   = SHIFT;
         end
         SHIFT: begin
            SRL_ctrl = 1'b1;
            count_d  = count_q + 6'd1;
            state_d  = (count_d < LAST_COUNT) ? CHECK : DONE;
         end
         DONE: begin
            Ready = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      done_d = (state_q == SHIFT) && (state_d == DONE);
   end

   assign Done  = done_q;
   assign Count = count_q;

endmodule

// File: tb/tb_mult_control.sv
// tb/tb_mult_control.sv - random and directed checks of mult_control driving a behavioural product register
module tb_mult_control;

   localparam int W = 32;

   logic        clk = 1'b0;
   logic        Reset, Run, lsb_x;
   logic        ADDU_ctrl, W_ctrl, SRL_ctrl, Ready, Done;
   logic [5:0]  Count;
   logic [31:0] mcand, mplier;
   logic [63:0] product;
   logic        carry_q;
   logic [32:0] sum;
   logic        lsb_w;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   mult_control #(.WIDTH(W)) dut (
      .clk(clk), .Reset(Reset), .Run(Run), .LSB(lsb_w),
      .ADDU_ctrl(ADDU_ctrl), .W_ctrl(W_ctrl), .SRL_ctrl(SRL_ctrl),
      .Ready(Ready), .Done(Done), .Count(Count)
   );

   // Datapath the controller is meant to steer: Product register, ALU and carry flop.
   assign sum   = {1'b0, product[63:32]} + {1'b0, mcand};
   assign lsb_w = lsb_x ? 1'bx : product[0];

   always @(posedge clk) begin
      if (Reset) begin
         product <= {32'd0, mplier};
         carry_q <= 1'b0;
      end else begin
         carry_q <= ADDU_ctrl ? sum[32] : 1'b0;
         if (W_ctrl)   product[63:32] <= sum[31:0];
         if (SRL_ctrl) product <= {carry_q, product[63:1]};
      end
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk1({tag, "_ready"}, Ready, 1'b1);
      chk1({tag, "_done"}, Done, 1'b0);
      chk1({tag, "_w"}, W_ctrl, 1'b0);
      chk1({tag, "_addu"}, ADDU_ctrl, 1'b0);
      chk1({tag, "_srl"}, SRL_ctrl, 1'b0);
      chk64({tag, "_count"}, 64'(Count), 64'd0);
   endtask

   // abort_k >= 0 asserts Reset during step abort_k (odd = SHIFT of iteration abort_k/2)
   task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                           input bit hold, input int abort_k, input bit xinj);
      logic [63:0] expect_p;
      expect_p = 64'(a) * 64'(b);
      mcand  = a;
      mplier = b;
      Reset  = 1'b1;
      Run    = hold;
      step();
      Reset  = 1'b0;
      chk_idle("post_reset");
      Run = 1'b1;
      step();
      if (!hold) Run = 1'b0;
      for (int k = 0; k < 2 * W; k++) begin
         int i;
         i = k / 2;
         if (k % 2 == 0) begin
            chk1("check_w", W_ctrl, b[i]);
            chk1("check_addu", ADDU_ctrl, b[i]);
            chk1("check_srl", SRL_ctrl, 1'b0);
         end else begin
            lsb_x = xinj;
            #1;
            chk1("shift_srl", SRL_ctrl, 1'b1);
            chk1("shift_w", W_ctrl, 1'b0);
            chk1("shift_addu", ADDU_ctrl, 1'b0);
            lsb_x = 1'b0;
         end
         chk1("busy_ready", Ready, 1'b0);
         chk1("busy_done", Done, 1'b0);
         chk64("busy_count", 64'(Count), 64'(i));
         if (k == abort_k) begin
            Reset = 1'b1;
            step();
            Reset = 1'b0;
            chk_idle("abort");
            for (int j = 0; j < 4; j++) begin
               step();
               chk_idle("abort_quiet");
            end
            return;
         end
         step();
      end
      chk1("done_pulse", Done, 1'b1);
      chk1("done_ready", Ready, 1'b1);
      chk1("done_srl", SRL_ctrl, 1'b0);
      chk1("done_w", W_ctrl, 1'b0);
      chk64("done_count", 64'(Count), 64'(W));
      chk64("product", product, expect_p);
      for (int j = 0; j < 4; j++) begin
         step();
         chk1("after_done", Done, 1'b0);
         chk1("after_ready", Ready, 1'b1);
         chk1("after_srl", SRL_ctrl, 1'b0);
         chk64("after_count", 64'(Count), 64'(W));
      end
      chk64("product_frozen", product, expect_p);
      Run = 1'b0;
   endtask

   initial begin
      Reset  = 1'b1;
      Run    = 1'b0;
      lsb_x  = 1'b0;
      mcand  = '0;
      mplier = '0;
      step();
      step();
      Reset = 1'b0;
      chk_idle("reset");
      step();
      chk_idle("idle_hold");

      run_mult(32'd3, 32'd5, 1'b0, -1, 1'b0);
      run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, 1'b0);
      run_mult($urandom, 32'd0, 1'b0, -1, 1'b0);
      run_mult($urandom, $urandom, 1'b0, 21, 1'b0);
      run_mult($urandom, $urandom, 1'b1, -1, 1'b0);
      run_mult($urandom, $urandom, 1'b0, -1, 1'b1);
      for (int r = 0; r < 4; r++) begin
         run_mult($urandom, $urandom, 1'($urandom_range(0, 1)), -1, 1'b0);
      end

      Reset = 1'b1;
      Run   = 1'b1;
      step();
      Reset = 1'b0;
      Run   = 1'b0;
      chk_idle("reset_run");
      Run = 1'b1;
      step();
      Run = 1'b0;
      chk1("rerun_ready", Ready, 1'b0);
      chk1("rerun_srl", SRL_ctrl, 1'b0);
      step();
      chk1("rerun_shift", SRL_ctrl, 1'b1);
      Reset = 1'b1;
      step();
      Reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
